// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the architectural PC, issues one imem request at a
// time, and fills the IF/ID register through a one-entry skid buffer.
module if_fetch_unit #(
    parameter int                     PC_WIDTH    = 64,
    parameter int                     INSTR_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]    RESET_PC    = '0,
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = 'h00000013
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [PC_WIDTH-1:0]    pc_next,
    input  logic                   redirect,
    input  logic                   stall,
    output logic [PC_WIDTH-1:0]    pc,
    output logic [PC_WIDTH-1:0]    pc_plus_4,
    output logic                   imem_req_valid,
    input  logic                   imem_req_ready,
    output logic [PC_WIDTH-1:0]    imem_req_addr,
    input  logic                   imem_resp_valid,
    input  logic [INSTR_WIDTH-1:0] imem_resp_data,
    output logic                   ifid_valid,
    output logic [PC_WIDTH-1:0]    ifid_pc,
    output logic [INSTR_WIDTH-1:0] ifid_instr
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        DROP  = 2'd2
    } state_t;

    state_t                 state_reg, state_next;
    logic [PC_WIDTH-1:0]    pc_reg, pc_next_val;
    logic [PC_WIDTH-1:0]    inflight_pc_reg, inflight_pc_next;
    logic                   ifid_valid_reg, ifid_valid_next;
    logic [PC_WIDTH-1:0]    ifid_pc_reg, ifid_pc_next;
    logic [INSTR_WIDTH-1:0] ifid_instr_reg, ifid_instr_next;
    logic                   skid_valid_reg, skid_valid_next;
    logic [PC_WIDTH-1:0]    skid_pc_reg, skid_pc_next;
    logic [INSTR_WIDTH-1:0] skid_instr_reg, skid_instr_next;
    logic                   req_valid;
    logic                   fire;
    logic                   deliver;

    // A full skid buffer blocks new requests, so it can never overflow.
    assign req_valid      = (state_reg == FETCH) && !skid_valid_reg && !rst;
    assign fire           = req_valid && imem_req_ready;
    assign deliver        = (state_reg == WAIT) && imem_resp_valid && !redirect;

    assign pc             = pc_reg;
    assign pc_plus_4      = pc_reg + PC_WIDTH'(4);
    assign imem_req_valid = req_valid;
    assign imem_req_addr  = pc_reg;
    assign ifid_valid     = ifid_valid_reg;
    assign ifid_pc        = ifid_pc_reg;
    assign ifid_instr     = ifid_instr_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            FETCH: if (fire) state_next = redirect ? DROP : WAIT;
            WAIT: begin
                if (imem_resp_valid) state_next = FETCH;
                else if (redirect)   state_next = DROP;
            end
            DROP: if (imem_resp_valid) state_next = FETCH;
            default: state_next = FETCH;
        endcase
    end

    always_comb begin
        pc_next_val      = (fire || redirect) ? pc_next : pc_reg;
        inflight_pc_next = fire ? pc_reg : inflight_pc_reg;
        ifid_valid_next  = ifid_valid_reg;
        ifid_pc_next     = ifid_pc_reg;
        ifid_instr_next  = ifid_instr_reg;
        skid_valid_next  = skid_valid_reg;
        skid_pc_next     = skid_pc_reg;
        skid_instr_next  = skid_instr_reg;

        if (deliver) begin
            if (stall && ifid_valid_reg) begin
                skid_valid_next = 1'b1;
                skid_pc_next    = inflight_pc_reg;
                skid_instr_next = imem_resp_data;
            end else begin
                ifid_valid_next = 1'b1;
                ifid_pc_next    = inflight_pc_reg;
                ifid_instr_next = imem_resp_data;
            end
        end else if (redirect) begin
            // Flush wins over stall: the wrong-path instruction must not reach ID.
            ifid_valid_next = 1'b0;
            ifid_instr_next = NOP_INSTR;
            skid_valid_next = 1'b0;
        end else if (!stall) begin
            if (skid_valid_reg) begin
                ifid_valid_next = 1'b1;
                ifid_pc_next    = skid_pc_reg;
                ifid_instr_next = skid_instr_reg;
                skid_valid_next = 1'b0;
            end else begin
                ifid_valid_next = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= FETCH;
            pc_reg          <= RESET_PC;
            inflight_pc_reg <= '0;
            ifid_valid_reg  <= 1'b0;
            ifid_pc_reg     <= '0;
            ifid_instr_reg  <= NOP_INSTR;
            skid_valid_reg  <= 1'b0;
            skid_pc_reg     <= '0;
            skid_instr_reg  <= '0;
        end else begin
            state_reg       <= state_next;
            pc_reg          <= pc_next_val;
            inflight_pc_reg <= inflight_pc_next;
            ifid_valid_reg  <= ifid_valid_next;
            ifid_pc_reg     <= ifid_pc_next;
            ifid_instr_reg  <= ifid_instr_next;
            skid_valid_reg  <= skid_valid_next;
            skid_pc_reg     <= skid_pc_next;
            skid_instr_reg  <= skid_instr_next;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed cycle table, async-reset/wrap sequences and a
// random phase, all checked against a PC model and an IF/ID scoreboard.
module tb_if_fetch_unit;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk;
    logic        rst;
    logic [63:0] pc_next;
    logic        redirect;
    logic        stall;
    logic [63:0] pc;
    logic [63:0] pc_plus_4;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        ifid_valid;
    logic [63:0] ifid_pc;
    logic [31:0] ifid_instr;
    logic [63:0] target;

    // Bench stands in for the next-PC mux.
    assign pc_next = redirect ? target : pc_plus_4;

    if_fetch_unit dut (
        .clk             (clk),
        .rst             (rst),
        .pc_next         (pc_next),
        .redirect        (redirect),
        .stall           (stall),
        .pc              (pc),
        .pc_plus_4       (pc_plus_4),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .ifid_valid      (ifid_valid),
        .ifid_pc         (ifid_pc),
        .ifid_instr      (ifid_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ready;
        logic        stl;
        logic        rdr;
        logic [63:0] tgt;
        int          lat;
        logic        e_req_valid;
        logic [63:0] e_pc;
        logic        e_ifid_valid;
        logic [63:0] e_ifid_pc;
        logic [31:0] e_ifid_instr;
    } vec_t;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
    } sb_t;

    sb_t         sbq[$];
    vec_t        tbl[26];
    vec_t        nv;
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] exp_pc;
    int          lat;
    logic        mem_pending;
    int          mem_cnt;
    logic [63:0] mem_addr;

    function automatic logic [31:0] instr_of(input logic [63:0] a);
        return {8'hA5, a[23:0]};
    endfunction

    function automatic vec_t mk(input logic rdy, input logic stl, input logic rdr,
                                input logic [63:0] tgt, input int lt, input logic rv,
                                input logic [63:0] p, input logic iv,
                                input logic [63:0] ip, input logic [31:0] ii);
        vec_t v;
        v.ready = rdy; v.stl = stl; v.rdr = rdr; v.tgt = tgt; v.lat = lt;
        v.e_req_valid = rv; v.e_pc = p; v.e_ifid_valid = iv;
        v.e_ifid_pc = ip; v.e_ifid_instr = ii;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // One clock cycle: inputs are already driven; check at negedge, update memory after posedge.
    task automatic step(input bit use_v, input vec_t v);
        sb_t e;
        logic fire;
        @(negedge clk);
        if (use_v) begin
            chk("tbl_req_valid",  {63'd0, imem_req_valid}, {63'd0, v.e_req_valid});
            chk("tbl_pc",         pc, v.e_pc);
            chk("tbl_req_addr",   imem_req_addr, v.e_pc);
            chk("tbl_ifid_valid", {63'd0, ifid_valid}, {63'd0, v.e_ifid_valid});
            chk("tbl_ifid_pc",    ifid_pc, v.e_ifid_pc);
            chk("tbl_ifid_instr", {32'd0, ifid_instr}, {32'd0, v.e_ifid_instr});
        end
        chk("model_pc", pc, exp_pc);
        chk("model_pc_plus_4", pc_plus_4, exp_pc + 64'd4);
        if (imem_req_valid) chk("model_req_addr", imem_req_addr, exp_pc);
        if (ifid_valid && !stall) begin
            if (sbq.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_empty: got ifid pc=%h instr=%h expected no valid instruction", ifid_pc, ifid_instr);
            end else begin
                e = sbq.pop_front();
                $display("ifid consumed pc=%h instr=%h (expected pc=%h instr=%h)", ifid_pc, ifid_instr, e.pc, e.instr);
                chk("sb_pc", ifid_pc, e.pc);
                chk("sb_instr", {32'd0, ifid_instr}, {32'd0, e.instr});
            end
        end
        fire = imem_req_valid && imem_req_ready;
        if (redirect) sbq.delete();
        if (fire) begin
            if (mem_pending) begin
                n_checks++;
                n_fail++;
                $display("FAIL one_outstanding: got second request addr=%h expected none", imem_req_addr);
            end
            mem_pending = 1'b1;
            mem_cnt     = lat;
            mem_addr    = imem_req_addr;
            if (!redirect) begin
                e.pc    = exp_pc;
                e.instr = instr_of(exp_pc);
                sbq.push_back(e);
            end
        end
        if (fire || redirect) exp_pc = redirect ? target : exp_pc + 64'd4;
        @(posedge clk);
        #1;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        if (mem_pending) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = instr_of(mem_addr);
                mem_pending     = 1'b0;
            end
        end
    endtask

    task automatic reset_models();
        sbq.delete();
        exp_pc          = 64'd0;
        mem_pending     = 1'b0;
        mem_cnt         = 0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
    endtask

    initial begin
        logic [63:0] t;
        rst = 1'b1; redirect = 1'b0; stall = 1'b0; target = '0;
        imem_req_ready = 1'b1; lat = 1;
        reset_models();

        //        rdy stl rdr tgt      lat  rv  pc       iv ifid_pc  ifid_instr
        tbl[0]  = mk(1, 0, 0, 64'h0,   1,   1, 64'h0,   0, 64'h0,   NOP);
        tbl[1]  = mk(1, 0, 0, 64'h0,   1,   0, 64'h4,   0, 64'h0,   NOP);
        tbl[2]  = mk(1, 0, 0, 64'h0,   1,   1, 64'h4,   1, 64'h0,   instr_of(64'h0));
        tbl[3]  = mk(1, 0, 0, 64'h0,   1,   0, 64'h8,   0, 64'h0,   instr_of(64'h0));
        tbl[4]  = mk(1, 0, 0, 64'h0,   1,   1, 64'h8,   1, 64'h4,   instr_of(64'h4));
        tbl[5]  = mk(1, 0, 0, 64'h0,   1,   0, 64'hC,   0, 64'h4,   instr_of(64'h4));
        tbl[6]  = mk(0, 0, 0, 64'h0,   1,   1, 64'hC,   1, 64'h8,   instr_of(64'h8));
        tbl[7]  = mk(0, 0, 0, 64'h0,   1,   1, 64'hC,   0, 64'h8,   instr_of(64'h8));
        tbl[8]  = mk(0, 0, 0, 64'h0,   1,   1, 64'hC,   0, 64'h8,   instr_of(64'h8));
        tbl[9]  = mk(1, 0, 0, 64'h0,   1,   1, 64'hC,   0, 64'h8,   instr_of(64'h8));
        tbl[10] = mk(1, 0, 0, 64'h0,   1,   0, 64'h10,  0, 64'h8,   instr_of(64'h8));
        tbl[11] = mk(1, 1, 0, 64'h0,   1,   1, 64'h10,  1, 64'hC,   instr_of(64'hC));
        tbl[12] = mk(1, 1, 0, 64'h0,   1,   0, 64'h14,  1, 64'hC,   instr_of(64'hC));
        tbl[13] = mk(1, 1, 0, 64'h0,   1,   0, 64'h14,  1, 64'hC,   instr_of(64'hC));
        tbl[14] = mk(1, 0, 0, 64'h0,   1,   0, 64'h14,  1, 64'hC,   instr_of(64'hC));
        tbl[15] = mk(1, 0, 0, 64'h0,   3,   1, 64'h14,  1, 64'h10,  instr_of(64'h10));
        tbl[16] = mk(1, 0, 1, 64'h100, 1,   0, 64'h18,  0, 64'h10,  instr_of(64'h10));
        tbl[17] = mk(1, 0, 0, 64'h0,   1,   0, 64'h100, 0, 64'h10,  NOP);
        tbl[18] = mk(1, 0, 0, 64'h0,   1,   0, 64'h100, 0, 64'h10,  NOP);
        tbl[19] = mk(1, 0, 0, 64'h0,   1,   1, 64'h100, 0, 64'h10,  NOP);
        tbl[20] = mk(1, 0, 0, 64'h0,   1,   0, 64'h104, 0, 64'h10,  NOP);
        tbl[21] = mk(1, 0, 1, 64'h200, 1,   1, 64'h104, 1, 64'h100, instr_of(64'h100));
        tbl[22] = mk(1, 0, 0, 64'h0,   1,   0, 64'h200, 0, 64'h100, NOP);
        tbl[23] = mk(1, 0, 0, 64'h0,   1,   1, 64'h200, 0, 64'h100, NOP);
        tbl[24] = mk(1, 0, 0, 64'h0,   1,   0, 64'h204, 0, 64'h100, NOP);
        tbl[25] = mk(1, 0, 0, 64'h0,   1,   1, 64'h204, 1, 64'h200, instr_of(64'h200));

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_pc", pc, 64'h0);
        chk("rst_req_valid", {63'd0, imem_req_valid}, 64'd0);
        chk("rst_ifid_valid", {63'd0, ifid_valid}, 64'd0);
        chk("rst_ifid_pc", ifid_pc, 64'h0);
        chk("rst_ifid_instr", {32'd0, ifid_instr}, {32'd0, NOP});
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 26; i++) begin
            imem_req_ready = tbl[i].ready;
            stall          = tbl[i].stl;
            redirect       = tbl[i].rdr;
            target         = tbl[i].tgt;
            lat            = tbl[i].lat;
            step(1'b1, tbl[i]);
        end

        // Fill the skid buffer, then hit it with an asynchronous reset mid-cycle.
        imem_req_ready = 1'b1; redirect = 1'b0; lat = 1;
        stall = 1'b0; step(1'b0, nv);
        stall = 1'b1; step(1'b0, nv);
        step(1'b0, nv);
        chk("skid_blocks_req", {63'd0, imem_req_valid}, 64'd0);
        chk("skid_ifid_held", ifid_pc, 64'h204);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_pc", pc, 64'h0);
        chk("async_rst_req_valid", {63'd0, imem_req_valid}, 64'd0);
        chk("async_rst_ifid_valid", {63'd0, ifid_valid}, 64'd0);
        chk("async_rst_ifid_pc", ifid_pc, 64'h0);
        chk("async_rst_ifid_instr", {32'd0, ifid_instr}, {32'd0, NOP});
        reset_models();
        stall = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("post_rst_req_valid", {63'd0, imem_req_valid}, 64'd1);
        chk("post_rst_req_addr", imem_req_addr, 64'h0);

        // Redirect together with a fire, to the top of the address space.
        redirect = 1'b1; target = 64'hFFFF_FFFF_FFFF_FFFC;
        step(1'b0, nv);
        redirect = 1'b0;
        chk("wrap_pc", pc, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap_pc_plus_4", pc_plus_4, 64'h0);

        for (int i = 0; i < 400; i++) begin
            imem_req_ready = ($urandom_range(0, 3) != 0);
            stall          = ($urandom_range(0, 3) == 0);
            redirect       = ($urandom_range(0, 15) == 0);
            t              = {$urandom(), $urandom()};
            t[1:0]         = 2'b00;
            target         = t;
            lat            = $urandom_range(1, 4);
            step(1'b0, nv);
        end

        imem_req_ready = 1'b1; stall = 1'b0; redirect = 1'b0; lat = 1;
        repeat (12) step(1'b0, nv);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage directly downstream of the next-PC mux.
- Holds the architectural PC, loads it from pc_next, and drives pc_plus_4 back to the mux.
- Issues one outstanding request at a time to instruction memory over a valid/ready request channel with a variable-latency response.
- Delivers {pc, instr} into the IF/ID pipeline register, with stall support, redirect flush, and a one-entry skid buffer.

Parameters:
- PC_WIDTH, 64, width of all PC/address signals.
- INSTR_WIDTH, 32, instruction word width.
- RESET_PC, 0, PC value loaded on reset.
- NOP_INSTR, 32'h00000013, ifid_instr value on reset and flush.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- pc_next  in  PC_WIDTH  next PC from the next-PC mux.
- redirect  in  1  branch taken or jump resolved this cycle; pc_next holds the target.
- stall  in  1  hazard unit holds IF/ID.
- pc  out  PC_WIDTH  current fetch PC.
- pc_plus_4  out  PC_WIDTH  pc + 4, combinational, to the mux.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  PC_WIDTH  equals pc.
- imem_resp_valid  in  1  response data valid.
- imem_resp_data  in  INSTR_WIDTH  fetched instruction.
- ifid_valid  out  1  IF/ID register holds a valid instruction.
- ifid_pc  out  PC_WIDTH  PC of the IF/ID instruction.
- ifid_instr  out  INSTR_WIDTH  IF/ID instruction.

Behaviour:
- Reset (async, immediate):
  - pc=RESET_PC, state=FETCH.
  - ifid_valid=0, ifid_pc=0, ifid_instr=NOP_INSTR.
  - skid empty, inflight_pc=0.
  - imem_req_valid forced 0 while rst=1.
- Arithmetic: pc_plus_4 = pc + 4, truncated to PC_WIDTH; wraps at all-ones.
- Request channel:
  - imem_req_valid = (state==FETCH) && !skid_valid.
  - fire = imem_req_valid && imem_req_ready.
  - At most one request outstanding. A response never arrives in the same cycle as its fire.
- PC register:
  - pc <= pc_next when (fire || redirect); otherwise hold.
  - On fire, inflight_pc <= pc.
- States:
  - FETCH: on fire: redirect → DROP, else → WAIT. Without fire: stay in FETCH (a redirect only updates pc).
  - WAIT: on imem_resp_valid: redirect → discard, FETCH; else → deliver (see below), FETCH. No response: redirect → DROP, else stay in WAIT.
  - DROP: on imem_resp_valid → discard, FETCH. A redirect while in DROP updates pc only.
- Deliver (WAIT response, no redirect):
  - If stall && ifid_valid: skid <= {inflight_pc, data}, skid_valid=1.
  - Otherwise: ifid <= {inflight_pc, data}, ifid_valid=1.
- IF/ID update when no delivery occurs in a cycle:
  - Redirect: ifid_valid=0, ifid_instr=NOP_INSTR, skid_valid=0. Redirect has priority over stall.
  - Else if stall: hold.
  - Else if skid_valid: ifid <= skid, skid_valid=0.
  - Else: ifid_valid=0 (bubble); ifid_pc and ifid_instr hold.
- Skid buffer: cannot overflow, because no request issues while skid_valid=1.
- Latency: a request fired at cycle T with its response at T+k gives ifid_valid=1 at T+k+1 (no stall). Minimum latency is therefore 2 cycles fire-to-IF/ID; throughput is 1 instruction per (k+1) cycles.
- imem_resp_valid outside WAIT/DROP is a protocol violation; it is ignored.
- Reset mid-WAIT: the outstanding response is discarded. The memory must also be reset by the same rst.

Test Plan:
- Reset release, memory with ready=1 and response latency 1:
  - Expect req_addr 0x0 and pc 0x4 after the first fire.
  - Expect ifid {pc=0x0, instr=resp} two cycles after the fire.
  - Expect sequential PCs 0x0, 0x4, 0x8.
- Hold imem_req_ready=0 for 3 cycles in FETCH → req_valid stays 1, req_addr and pc hold; no IF/ID change besides bubbles.
- stall=1 with ifid_valid=1 while a response returns:
  - Response lands in skid; ifid unchanged; req_valid=0.
  - On release, ifid gets the skid entry on the next edge, then fetch resumes.
- redirect=1 with pc_next=0x100 while in WAIT:
  - ifid_valid=0, ifid_instr=NOP_INSTR.
  - The late response is discarded (DROP).
  - Next req_addr is 0x100 and ifid_pc is 0x100 afterwards.
- redirect and fire in the same cycle:
  - pc=target, state DROP.
  - The response of the fired request never appears in IF/ID.
- rst asserted mid-WAIT with skid full:
  - Outputs return to reset values immediately (async), before the next edge.
  - After release, req_addr=RESET_PC.
